// File: rtl/my_onehot_decoder.sv
// Index-to-one-hot decoder behind a 2-entry (output + skid) elastic buffer,
// with a sticky visited mask and a saturating accepted-transfer counter.
module my_onehot_decoder #(
    parameter int   IN_WIDTH  = 6,
    parameter int   OUT_WIDTH = 48,
    parameter logic ACTIVE    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_index,
    input  logic                 in_invalid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_error,
    input  logic                 clear,
    output logic [OUT_WIDTH-1:0] visited,
    output logic [15:0]          xfer_count
);

    localparam int unsigned OUT_W = OUT_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OUT   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 load_out_in;
    logic                 load_out_skid;
    logic                 load_skid;

    logic                 in_range;
    logic                 dec_sel;
    logic                 dec_err;
    logic [OUT_WIDTH-1:0] dec_vec;
    logic [OUT_WIDTH-1:0] hit_vec;

    logic [OUT_WIDTH-1:0] skid_vec;
    logic                 skid_err;

    logic [OUT_WIDTH-1:0] visited_base;
    logic [OUT_WIDTH-1:0] visited_next;
    logic [15:0]          count_base;
    logic [15:0]          count_next;

    assign accept = in_valid & in_ready;

    always_comb begin
        in_range = (32'(in_index) < OUT_W);
        dec_sel  = ~in_invalid & in_range;
        dec_err  = ~in_invalid & ~in_range;
        dec_vec  = {OUT_WIDTH{~ACTIVE}};
        hit_vec  = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (dec_sel && (32'(in_index) == i)) begin
                dec_vec[i] = ACTIVE;
                hit_vec[i] = 1'b1;
            end
        end
    end

    // Skid can only fill while the output stage holds undelivered data, so
    // ST_FULL always implies the output stage is occupied as well.
    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_out_in = 1'b1;
                    state_next  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (accept) begin
                        load_out_in = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    load_out_skid = 1'b1;
                    state_next    = ST_OUT;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Handshake outputs are flopped from the next-state decode so neither
    // depends combinationally on the current cycle's inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != ST_FULL);
            out_valid <= (state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= {OUT_WIDTH{~ACTIVE}};
            out_error <= 1'b0;
            skid_vec  <= {OUT_WIDTH{~ACTIVE}};
            skid_err  <= 1'b0;
        end else begin
            if (load_out_skid) begin
                out       <= skid_vec;
                out_error <= skid_err;
            end else if (load_out_in) begin
                out       <= dec_vec;
                out_error <= dec_err;
            end
            if (load_skid) begin
                skid_vec <= dec_vec;
                skid_err <= dec_err;
            end
        end
    end

    always_comb begin
        visited_base = clear ? '0 : visited;
        count_base   = clear ? '0 : xfer_count;
        visited_next = visited_base;
        count_next   = count_base;
        if (accept) begin
            visited_next = visited_base | hit_vec;
            if (count_base != 16'hFFFF) begin
                count_next = count_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            visited    <= '0;
            xfer_count <= '0;
        end else begin
            visited    <= visited_next;
            xfer_count <= count_next;
        end
    end

endmodule

// File: tb/tb_my_onehot_decoder.sv
// Directed bench for my_onehot_decoder (default parameters) plus a
// scoreboarded random handshake phase checking ordering and occupancy.
module tb_my_onehot_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_index;
    logic        in_invalid;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out;
    logic        out_error;
    logic        clear;
    logic [47:0] visited;
    logic [15:0] xfer_count;

    int checks;
    int failures;

    typedef struct packed {
        logic [47:0] vec;
        logic        err;
    } entry_t;

    entry_t sb[$];

    my_onehot_decoder #(
        .IN_WIDTH (6),
        .OUT_WIDTH(48),
        .ACTIVE   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_invalid(in_invalid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_error (out_error),
        .clear     (clear),
        .visited   (visited),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t model(input logic [5:0] idx, input logic inv);
        entry_t e;
        e.vec = '1;
        e.err = 1'b0;
        if (!inv) begin
            if (idx < 6'd48) e.vec[idx] = 1'b0;
            else e.err = 1'b1;
        end
        return e;
    endfunction

    initial begin
        entry_t got;
        entry_t exp_e;
        logic   acc;
        logic   dlv;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_index   = '0;
        in_invalid = 1'b0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out", 64'(out), 64'hFFFF_FFFF_FFFF);
        check("rst_out_error", 64'(out_error), 64'd0);
        check("rst_visited", 64'(visited), 64'd0);
        check("rst_count", 64'(xfer_count), 64'd0);
        #10 rst = 1'b0;

        // Basic decode of index 3
        in_valid = 1'b1; in_index = 6'd3; out_ready = 1'b1;
        step();
        check("idx3_valid", 64'(out_valid), 64'd1);
        check("idx3_out", 64'(out), 64'hFFFF_FFFF_FFF7);
        check("idx3_err", 64'(out_error), 64'd0);
        check("idx3_visited", 64'(visited), 64'h8);
        check("idx3_count", 64'(xfer_count), 64'd1);
        in_valid = 1'b0;
        step();
        check("idx3_drained", 64'(out_valid), 64'd0);

        // Out-of-range and invalid indices
        in_valid = 1'b1; in_index = 6'd50; in_invalid = 1'b0;
        step();
        check("oor50_out", 64'(out), 64'hFFFF_FFFF_FFFF);
        check("oor50_err", 64'(out_error), 64'd1);
        check("oor50_visited", 64'(visited), 64'h8);
        in_index = 6'd5; in_invalid = 1'b1;
        step();
        check("inv5_out", 64'(out), 64'hFFFF_FFFF_FFFF);
        check("inv5_err", 64'(out_error), 64'd0);
        check("inv5_visited", 64'(visited), 64'h8);
        check("inv5_count", 64'(xfer_count), 64'd3);
        in_invalid = 1'b0; in_index = 6'd48;
        step();
        check("oor48_err", 64'(out_error), 64'd1);
        in_index = 6'd47;
        step();
        check("idx47_out", 64'(out), 64'h7FFF_FFFF_FFFF);
        check("idx47_err", 64'(out_error), 64'd0);
        check("idx47_visited", 64'(visited), 64'h8000_0000_0008);
        in_valid = 1'b0;
        step();

        // Backpressure fills the skid
        out_ready = 1'b0; in_valid = 1'b1; in_index = 6'd1;
        step();
        check("bp1_out", 64'(out), 64'hFFFF_FFFF_FFFD);
        check("bp1_ready", 64'(in_ready), 64'd1);
        in_index = 6'd2;
        step();
        check("bp2_ready", 64'(in_ready), 64'd0);
        check("bp2_out", 64'(out), 64'hFFFF_FFFF_FFFD);
        in_valid = 1'b0;
        step();
        check("bp_hold_out", 64'(out), 64'hFFFF_FFFF_FFFD);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_dlv2_out", 64'(out), 64'hFFFF_FFFF_FFFB);
        check("bp_dlv2_valid", 64'(out_valid), 64'd1);
        check("bp_dlv2_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_visited", 64'(visited), 64'h8000_0000_000E);
        check("bp_count", 64'(xfer_count), 64'd7);

        // Clear coincident with accept
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_visited", 64'(visited), 64'd0);
        check("clr_count", 64'(xfer_count), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_index = 6'(i);
            step();
        end
        check("ff_visited", 64'(visited), 64'hFF);
        clear = 1'b1; in_index = 6'd7;
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clracc_visited", 64'(visited), 64'h80);
        check("clracc_count", 64'(xfer_count), 64'd1);
        check("clracc_out", 64'(out), 64'hFFFF_FFFF_FF7F);
        step();

        // Reset with both entries occupied
        out_ready = 1'b0; in_valid = 1'b1; in_index = 6'd9;
        step();
        in_index = 6'd10;
        step();
        in_valid = 1'b0;
        check("prerst_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_out", 64'(out), 64'hFFFF_FFFF_FFFF);
        check("midrst_visited", 64'(visited), 64'd0);
        check("midrst_count", 64'(xfer_count), 64'd0);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("postrst_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_index = 6'd4;
        step();
        check("postrst_out", 64'(out), 64'hFFFF_FFFF_FFEF);
        check("postrst_count", 64'(xfer_count), 64'd1);
        in_valid = 1'b0;
        step();
        check("postrst_drain", 64'(out_valid), 64'd0);

        // Random handshake traffic against a scoreboard
        sb.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_index   = 6'($urandom_range(0, 63));
            in_invalid = ($urandom_range(0, 7) == 0);
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
            check("rnd_out_valid", 64'(out_valid), 64'(sb.size() > 0));
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv && sb.size() > 0) begin
                exp_e = sb.pop_front();
                got.vec = out;
                got.err = out_error;
                check("rnd_data", 64'(got), 64'(exp_e));
            end
            if (acc) sb.push_back(model(in_index, in_invalid));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid && sb.size() > 0) begin
                exp_e = sb.pop_front();
                got.vec = out;
                got.err = out_error;
                check("rnd_drain", 64'(got), 64'(exp_e));
            end
            step();
        end
        check("rnd_sb_empty", 64'(sb.size()), 64'd0);
        check("rnd_final_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
